// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and oversampling constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    localparam int OVS = 16;
    localparam int MID = 7;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing a one-cycle oversample tick
module uart_baud_gen #(
    parameter int BAUD_DIV = 326
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = r_cnt == CW'(BAUD_DIV - 1);
    assign o_tick = w_wrap;

    // count 0..BAUD_DIV-1 continuously; never restarted by frame activity
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_rx_bip.sv
// uart_rx_bip: 8N1 UART receiver, 16x oversampled, one-byte holding register with error flags
module uart_rx_bip
    import uart_pkg::*;
#(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 326
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rx,
    input  logic            i_rd,
    output logic [DBIT-1:0] o_dout,
    output logic            o_valid,
    output logic            o_frame_err,
    output logic            o_overrun
);

    localparam int NW = DBIT > 1 ? $clog2(DBIT) : 1;

    logic            r_rx_m;
    logic            r_rx_s;
    logic            w_tick;
    state_t          r_state;
    logic [3:0]      r_s_cnt;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_sh;
    logic            r_commit;
    logic            r_ferr;

    uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_tick (w_tick)
    );

    // two-flop synchronizer; line idles high so reset to 1
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) {r_rx_m, r_rx_s} <= 2'b11;
        else          {r_rx_m, r_rx_s} <= {i_rx, r_rx_m};
    end

    // frame FSM: mid-bit sampling, LSB-first shift, one-cycle commit/error pulses
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_s_cnt  <= '0;
            r_n      <= '0;
            r_sh     <= '0;
            r_commit <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            r_ferr   <= 1'b0;
            case (r_state)
                IDLE: if (!r_rx_s) begin
                    r_state <= START;
                    r_s_cnt <= '0;
                end
                START: if (w_tick) begin
                    if (r_s_cnt == 4'(MID)) begin
                        r_state <= r_rx_s ? IDLE : DATA;
                        r_s_cnt <= '0;
                        r_n     <= '0;
                    end else r_s_cnt <= r_s_cnt + 4'd1;
                end
                DATA: if (w_tick) begin
                    if (r_s_cnt == 4'(OVS - 1)) begin
                        r_sh    <= {r_rx_s, r_sh[DBIT-1:1]};
                        r_s_cnt <= '0;
                        if (r_n == NW'(DBIT - 1)) r_state <= STOP;
                        else                      r_n <= r_n + 1'b1;
                    end else r_s_cnt <= r_s_cnt + 4'd1;
                end
                STOP: if (w_tick) begin
                    if (r_s_cnt == 4'(SB_TICK - 1)) begin
                        r_state  <= r_rx_s ? IDLE : BRK;
                        r_commit <= r_rx_s;
                        r_ferr   <= !r_rx_s;
                        r_s_cnt  <= '0;
                    end else r_s_cnt <= r_s_cnt + 4'd1;
                end
                BRK: if (r_rx_s) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // holding register and sticky flags; a commit beats a same-cycle read for VALID/DOUT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_dout      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (i_rd) begin
                o_valid     <= 1'b0;
                o_frame_err <= 1'b0;
                o_overrun   <= 1'b0;
            end
            if (r_commit && (!o_valid || i_rd)) begin
                o_dout  <= r_sh;
                o_valid <= 1'b1;
            end
            if (r_commit && o_valid && !i_rd) o_overrun <= 1'b1;
            if (r_ferr) o_frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_bip.sv
// tb_uart_rx_bip: directed frames with a byte scoreboard popped on each VALID rise
module tb_uart_rx_bip;

    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;

    uart_rx_bip #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx),
        .i_rd       (rd),
        .o_dout     (dout),
        .o_valid    (valid),
        .o_frame_err(frame_err),
        .o_overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic rd_pulse();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid && !prev_valid) begin
            if (exp_q.size() == 0) check("unexpected_valid", 32'(dout), 32'hx);
            else check("scoreboard_dout", 32'(dout), 32'(exp_q.pop_front()));
        end
        prev_valid = valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        check("t1_valid", 32'(valid), 32'h1);
        check("t1_ferr", 32'(frame_err), 32'h0);
        rd_pulse();
        check("t1_rd_valid", 32'(valid), 32'h0);

        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        check("t2_valid", 32'(valid), 32'h1);
        rd_pulse();
        check("t2_rd_valid", 32'(valid), 32'h0);
        check("t2_dout", 32'(dout), 32'hA3);

        @(negedge clk) rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        check("t3_valid", 32'(valid), 32'h0);
        check("t3_ferr", 32'(frame_err), 32'h0);
        check("t3_ovr", 32'(overrun), 32'h0);

        send_frame(8'h0F, 1'b0);
        repeat (200) @(negedge clk);
        check("t4_ferr", 32'(frame_err), 32'h1);
        check("t4_valid", 32'(valid), 32'h0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        check("t4_valid2", 32'(valid), 32'h1);
        check("t4_ferr_sticky", 32'(frame_err), 32'h1);
        rd_pulse();
        check("t4_rd_ferr", 32'(frame_err), 32'h0);
        check("t4_rd_valid", 32'(valid), 32'h0);

        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        repeat (16) @(negedge clk);
        send_frame(8'h22, 1'b1);
        check("t5_dout", 32'(dout), 32'h11);
        check("t5_ovr", 32'(overrun), 32'h1);
        check("t5_valid", 32'(valid), 32'h1);
        rd_pulse();
        check("t5_rd_valid", 32'(valid), 32'h0);
        check("t5_rd_ovr", 32'(overrun), 32'h0);

        @(negedge clk) rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            repeat (BIT) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("t6_rst_dout", 32'(dout), 32'h0);
        check("t6_rst_valid", 32'(valid), 32'h0);
        check("t6_rst_flags", 32'({frame_err, overrun}), 32'h0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        exp_q.push_back(8'hC8);
        send_frame(8'hC8, 1'b1);
        check("t6_valid", 32'(valid), 32'h1);
        check("t6_dout", 32'(dout), 32'hC8);
        check("t6_flags", 32'({frame_err, overrun}), 32'h0);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
